zero_count_norm: RTL and testbench

- Leading-zero counter and normalizer for the floating-point datapath.
- Counts the zeros above the most significant set bit of an unsigned mantissa word.
- Outputs that count together with the word shifted left so its MSB is 1.
- Used after add/subtract to renormalize mantissas before exponent adjustment.

---
 rtl/zero_count_norm.sv | 70 +++++++
 tb/tb_zero_count_norm.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/zero_count_norm.sv
// Leading-zero counter and normalizer: reports the zeros above the top set bit
// and returns the word shifted so its MSB is 1. Optional single output register.
module zero_count_norm #(
  parameter int WIDTH      = 24,
  parameter int WIDTHR     = 5,
  parameter int REGISTERED = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  data,
  output logic [WIDTHR-1:0] distance,
  output logic [WIDTH-1:0]  result
);

  if ((2 ** WIDTHR) <= WIDTH) begin : g_bad_widthr
    $error("zero_count_norm: 2**WIDTHR must exceed WIDTH");
  end

  logic [WIDTHR-1:0] dcnt;
  logic [WIDTHR-1:0] dist_c;
  logic [WIDTH-1:0]  res_c;
  logic              zero;

  // Stage k consumes the word from stage k+1; the top stage takes data directly.
  for (genvar k = 0; k < WIDTHR; k++) begin : g_stage
    localparam int S = 1 << k;
    localparam int T = (S < WIDTH) ? S : WIDTH;
    logic [WIDTH-1:0] win;
    logic [WIDTH-1:0] wout;
    logic             hit;

    if (k == WIDTHR-1) begin : g_top
      assign win = data;
    end else begin : g_mid
      assign win = g_stage[k+1].wout;
    end

    assign hit     = ~|win[WIDTH-1 -: T];
    assign dcnt[k] = hit;

    if (S < WIDTH) begin : g_sh
      assign wout = hit ? (win << S) : win;
    end else begin : g_clr
      assign wout = hit ? '0 : win;
    end
  end

  // All-zero input would otherwise report 2**WIDTHR-1.
  assign zero   = ~|data;
  assign dist_c = zero ? WIDTHR'(WIDTH) : dcnt;
  assign res_c  = g_stage[0].wout;

  if (REGISTERED != 0) begin : g_reg
    always_ff @(posedge clock) begin
      if (reset) begin
        distance <= '0;
        result   <= '0;
      end else begin
        distance <= dist_c;
        result   <= res_c;
      end
    end
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clock ^ reset;
    assign distance = dist_c;
    assign result   = res_c;
  end

endmodule

// File: tb/tb_zero_count_norm.sv
// Scoreboard bench: combinational and registered instances share one data stream;
// expected values come from a bit-scanning reference model or fixed spot values.
module tb_zero_count_norm;
  localparam int W  = 24;
  localparam int WR = 5;

  typedef struct packed {
    logic [WR-1:0] d;
    logic [W-1:0]  r;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  data = '0;
  logic [WR-1:0] dist_c, dist_r;
  logic [W-1:0]  res_c, res_r;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  exp_t          q_c[$];
  exp_t          q_r[$];

  zero_count_norm #(.WIDTH(W), .WIDTHR(WR), .REGISTERED(0)) u_comb (
    .clock(clk), .reset(reset), .data(data), .distance(dist_c), .result(res_c));

  zero_count_norm #(.WIDTH(W), .WIDTHR(WR), .REGISTERED(1)) u_reg (
    .clock(clk), .reset(reset), .data(data), .distance(dist_r), .result(res_r));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: scan from the MSB counting zeros, then shift by that count.
  function automatic void model(input logic [W-1:0] v, output logic [WR-1:0] d,
                                output logic [W-1:0] r);
    int n;
    n = 0;
    for (int i = W-1; i >= 0; i--) begin
      if (v[i]) break;
      n++;
    end
    d = WR'(n);
    r = (n >= W) ? '0 : (v << n);
  endfunction

  task automatic chk(input string name, input int c, input logic [WR-1:0] ad,
                     input logic [W-1:0] ar, input exp_t e);
    checks++;
    if (ad !== e.d || ar !== e.r) begin
      errors++;
      $display("FAIL %s cyc=%0d got dist=%0d res=%06h expected dist=%0d res=%06h",
               name, c, ad, ar, e.d, e.r);
    end
  endtask

  // Drive one data word for a cycle; known=1 uses fixed expected values instead of the model.
  task automatic drive(input logic [W-1:0] v, input logic r, input logic known,
                       input logic [WR-1:0] kd, input logic [W-1:0] kr);
    exp_t e;
    logic [WR-1:0] md;
    logic [W-1:0]  mr;
    @(posedge clk);
    #1;
    data  = v;
    reset = r;
    model(v, md, mr);
    e.d = known ? kd : md;
    e.r = known ? kr : mr;
    e.due = cyc;
    q_c.push_back(e);
    if (r) begin
      e.d = '0;
      e.r = '0;
    end
    e.due = cyc + 1;
    q_r.push_back(e);
  endtask

  task automatic send(input logic [W-1:0] v);
    drive(v, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic spot(input logic [W-1:0] v, input logic [WR-1:0] d, input logic [W-1:0] r);
    drive(v, 1'b0, 1'b1, d, r);
  endtask

  // Monitor: compare whichever expected entries fall due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q_c.size() > 0 && q_c[0].due <= cyc) begin
        e = q_c.pop_front();
        chk(e.due == cyc ? "comb" : "comb_late", cyc, dist_c, res_c, e);
      end
      while (q_r.size() > 0 && q_r[0].due <= cyc) begin
        e = q_r.pop_front();
        chk(e.due == cyc ? "reg" : "reg_late", cyc, dist_r, res_r, e);
      end
    end
  end

  initial begin
    logic [W-1:0] v;
    // Reset held for two edges: registered outputs must read zero.
    drive(24'h123456, 1'b1, 1'b0, '0, '0);
    drive(24'h000000, 1'b1, 1'b0, '0, '0);
    spot(24'h000001, 5'd23, 24'h800000);
    for (int i = 0; i < 2048; i++) send(W'(i));
    spot(24'h0007FF, 5'd13, 24'hFFE000);
    spot(24'h000400, 5'd13, 24'h800000);
    spot(24'h000000, 5'd24, 24'h000000);
    spot(24'h800000, 5'd0,  24'h800000);
    spot(24'hFFFFFF, 5'd0,  24'hFFFFFF);
    spot(24'h00ABCD, 5'd8,  24'hABCD00);
    for (int n = 0; n < W; n++) spot(W'(1) << n, WR'(W-1-n), 24'h800000);
    // Mid-stream reset, then resume.
    send(24'h0F0000);
    drive(24'h000100, 1'b1, 1'b0, '0, '0);
    spot(24'h000100, 5'd15, 24'h800000);
    // Back-to-back through the register.
    spot(24'h400000, 5'd1,  24'h800000);
    spot(24'h000003, 5'd22, 24'hC00000);
    spot(24'h000000, 5'd24, 24'h000000);
    for (int i = 0; i < 500; i++) begin
      v = W'($urandom) >> $urandom_range(0, W);
      send(v);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q_c.size() != 0 || q_r.size() != 0) begin
      errors++;
      $display("FAIL drain got comb=%0d reg=%0d pending expected 0", q_c.size(), q_r.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
